ram_arbiter: RTL and testbench

Three-way arbiter sharing the CPU's single-port RAM between instruction fetch (port 0), data load/store (port 1) and the debug/program-loader port (port 2). Sits between the `cpu` fetch/execute logic and the RAM instance, replacing direct RAM wiring. Serialises accesses through a 3-state FSM, issues one registered RAM command per grant and returns read data with a one-cycle `rvalid` pulse to the owning requester.

---
 rtl/ram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Three-way arbiter sharing a single-port synchronous RAM between
//            instruction fetch (port 0, read-only), data load/store (port 1)
//            and the debug/program-loader port (port 2). One registered RAM
//            command per grant; reads return data with a one-cycle rvalid.
// Options  : RAM_ARB_ROUND_ROBIN_EN - round-robin arbitration with a last-
//            winner pointer; undefined selects fixed priority 2 > 1 > 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        owner_q;
    logic [2:0]        gnt_q;
    logic [2:0]        rvalid_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    // Arbitration result, consumed only on the IDLE -> CMD transition
    logic [1:0]        owner_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q;
    logic [1:0] search0;
    logic [1:0] search1;
    logic [1:0] search2;

    // Search order begins one past the last winner, wrapping modulo 3
    always_comb begin
        search0 = 2'd0;
        search1 = 2'd1;
        search2 = 2'd2;
        case (ptr_q)
            2'd0: begin search0 = 2'd1; search1 = 2'd2; search2 = 2'd0; end
            2'd1: begin search0 = 2'd2; search1 = 2'd0; search2 = 2'd1; end
            default: begin search0 = 2'd0; search1 = 2'd1; search2 = 2'd2; end
        endcase
    end
`endif

    // Pick the winning port and mux its command fields
    always_comb begin
        owner_d = 2'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (req[search0])
            owner_d = search0;
        else if (req[search1])
            owner_d = search1;
        else
            owner_d = search2;
`else
        if (req[2])
            owner_d = 2'd2;
        else if (req[1])
            owner_d = 2'd1;
        else
            owner_d = 2'd0;
`endif
        case (owner_d)
            2'd2: begin
                we_d    = we2;
                addr_d  = addr2;
                wdata_d = wdata2;
            end
            2'd1: begin
                we_d    = we1;
                addr_d  = addr1;
                wdata_d = wdata1;
            end
            default: begin
                // Instruction fetch can never write
                we_d    = 1'b0;
                addr_d  = addr0;
                wdata_d = '0;
            end
        endcase
    end

    // Arbiter FSM with all outputs registered from state and owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 2'd0;
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ptr_q       <= 2'd2;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    rvalid_q <= 3'b000;
                    if (req != 3'b000) begin
                        state_q     <= S_CMD;
                        owner_q     <= owner_d;
                        gnt_q       <= 3'b001 << owner_d;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= we_d;
                        ram_addr_q  <= addr_d;
                        ram_wdata_q <= wdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        ptr_q       <= owner_d;
`endif
                    end
                end
                S_CMD: begin
                    gnt_q    <= 3'b000;
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    // ram_we_q still holds the owner's write flag this cycle
                    if (ram_we_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q  <= S_RESP;
                        rvalid_q <= 3'b001 << owner_q;
                    end
                end
                S_RESP: begin
                    rvalid_q <= 3'b000;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    gnt_q    <= 3'b000;
                    rvalid_q <= 3'b000;
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    // RAM read data is already one cycle behind ram_en, aligned with RESP
    assign rdata     = ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Self-checking bench for ram_arbiter with a behavioural
//            synchronous single-port RAM. Expected arbitration order follows
//            RAM_ARB_ROUND_ROBIN_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic       we1, we2;
    logic [7:0] addr0, addr1, addr2;
    logic [7:0] wdata1, wdata2;
    logic [2:0] gnt, rvalid;
    logic [7:0] rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata;

    logic       load_en;
    logic [7:0] load_addr, load_data;
    logic [7:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we1       (we1),
        .we2       (we2),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .wdata1    (wdata1),
        .wdata2    (wdata2),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous-read RAM; a load port preloads contents before traffic
    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (ram_en) begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [2:0] req;
        logic       we1, we2;
        logic [7:0] a0, a1, a2, d1, d2;
        logic [2:0] egnt;
        logic       ewe;
        logic [7:0] eaddr, ewdata, erdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 3'b000; we1 = 1'b0; we2 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; addr2 = 8'h00;
        wdata1 = 8'h00; wdata2 = 8'h00;
    endtask

    // One transaction from IDLE: CMD check, then RESP check for reads
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        req = v.req; we1 = v.we1; we2 = v.we2;
        addr0 = v.a0; addr1 = v.a1; addr2 = v.a2;
        wdata1 = v.d1; wdata2 = v.d2;
        tick();
        chk($sformatf("v%0d_gnt", i),    {29'd0, gnt},    {29'd0, v.egnt});
        chk($sformatf("v%0d_en", i),     {31'd0, ram_en}, 32'd1);
        chk($sformatf("v%0d_we", i),     {31'd0, ram_we}, {31'd0, v.ewe});
        chk($sformatf("v%0d_addr", i),   {24'd0, ram_addr}, {24'd0, v.eaddr});
        chk($sformatf("v%0d_rv_cmd", i), {29'd0, rvalid}, 32'd0);
        if (v.ewe)
            chk($sformatf("v%0d_wdata", i), {24'd0, ram_wdata}, {24'd0, v.ewdata});
        idle_inputs();
        tick();
        chk($sformatf("v%0d_en_off", i),  {31'd0, ram_en}, 32'd0);
        chk($sformatf("v%0d_gnt_off", i), {29'd0, gnt},    32'd0);
        if (!v.ewe) begin
            chk($sformatf("v%0d_rvalid", i), {29'd0, rvalid}, {29'd0, v.egnt});
            chk($sformatf("v%0d_rdata", i),  {24'd0, rdata},  {24'd0, v.erdata});
            tick();
            chk($sformatf("v%0d_rv_off", i), {29'd0, rvalid}, 32'd0);
        end else begin
            chk($sformatf("v%0d_wr_norv", i), {29'd0, rvalid}, 32'd0);
        end
    endtask

    logic [2:0] exp_ord3 [3];
    logic [2:0] exp_ord4 [4];
    logic [7:0] pre_a [3];
    logic [7:0] pre_d [3];

    initial begin
        int n;
        int ngr;
        int last_cyc;
        int cyc;
        logic prev_wr;
        int rv0, rv1, rv2;

        //                  req     we1   we2   a0     a1     a2     d1     d2     gnt     we    addr   wdata  rdata
        vecs[0]  = '{3'b001, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[1]  = '{3'b010, 1'b1, 1'b0, 8'h00, 8'h20, 8'h00, 8'h3C, 8'h00, 3'b010, 1'b1, 8'h20, 8'h3C, 8'h00};
        vecs[2]  = '{3'b010, 1'b0, 1'b0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'h20, 8'h00, 8'h3C};
        vecs[3]  = '{3'b100, 1'b0, 1'b1, 8'h00, 8'h00, 8'h30, 8'h00, 8'h5A, 3'b100, 1'b1, 8'h30, 8'h5A, 8'h00};
        vecs[4]  = '{3'b001, 1'b0, 1'b0, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 8'h30, 8'h00, 8'h5A};
        vecs[5]  = '{3'b100, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 3'b100, 1'b0, 8'hFF, 8'h00, 8'h77};
        vecs[6]  = '{3'b010, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 3'b010, 1'b1, 8'hFF, 8'h00, 8'h00};
        vecs[7]  = '{3'b100, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 3'b100, 1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[8]  = '{3'b100, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3, 3'b100, 1'b1, 8'h00, 8'hC3, 8'h00};
        vecs[9]  = '{3'b001, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 8'h00, 8'h00, 8'hC3};
        // Port 0 read while the other write enables and data are active
        vecs[10] = '{3'b001, 1'b1, 1'b1, 8'h05, 8'h05, 8'h05, 8'hEE, 8'hEE, 3'b001, 1'b0, 8'h05, 8'h00, 8'h11};
        vecs[11] = '{3'b010, 1'b0, 1'b0, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 3'b010, 1'b0, 8'h05, 8'h00, 8'h11};

        pre_a[0] = 8'h10; pre_d[0] = 8'hA5;
        pre_a[1] = 8'hFF; pre_d[1] = 8'h77;
        pre_a[2] = 8'h05; pre_d[2] = 8'h11;

`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_ord3[0] = 3'b001; exp_ord3[1] = 3'b010; exp_ord3[2] = 3'b100;
        exp_ord4[0] = 3'b001; exp_ord4[1] = 3'b100; exp_ord4[2] = 3'b001; exp_ord4[3] = 3'b100;
`else
        exp_ord3[0] = 3'b100; exp_ord3[1] = 3'b010; exp_ord3[2] = 3'b001;
        exp_ord4[0] = 3'b100; exp_ord4[1] = 3'b100; exp_ord4[2] = 3'b100; exp_ord4[3] = 3'b100;
`endif

        // Reset with RAM preload
        reset = 1'b0;
        idle_inputs();
        load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        for (int k = 0; k < 3; k++) begin
            load_en = 1'b1; load_addr = pre_a[k]; load_data = pre_d[k];
            tick();
        end
        load_en = 1'b0;
        chk("rst_gnt",    {29'd0, gnt},      32'd0);
        chk("rst_rvalid", {29'd0, rvalid},   32'd0);
        chk("rst_en",     {31'd0, ram_en},   32'd0);
        chk("rst_we",     {31'd0, ram_we},   32'd0);
        chk("rst_addr",   {24'd0, ram_addr}, 32'd0);
        chk("rst_wdata",  {24'd0, ram_wdata},32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("idle_no_req_gnt", {29'd0, gnt}, 32'd0);

        // Single-requester vector table
        for (int i = 0; i < 12; i++)
            run_vec(i);

        // Write then a one-cycle-delayed read: second grant 3 cycles later
        req = 3'b010; we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'h66;
        tick();
        chk("b2b_wr_gnt", {29'd0, gnt}, 32'd2);
        idle_inputs();
        n = 0;
        tick(); n++;
        tick(); n++;
        req = 3'b010; we1 = 1'b0; addr1 = 8'h21;
        begin : wait_gnt
            for (int k = 0; k < 10; k++) begin
                tick(); n++;
                if (gnt != 3'b000) disable wait_gnt;
            end
        end
        chk("b2b_gap", n, 32'd3);
        chk("b2b_rd_gnt", {29'd0, gnt}, 32'd2);
        idle_inputs();
        tick();
        chk("b2b_rvalid", {29'd0, rvalid}, 32'd2);
        chk("b2b_rdata",  {24'd0, rdata},  32'h66);
        tick();

        // Reset asserted asynchronously during RESP of a read
        req = 3'b001; addr0 = 8'h10;
        tick();
        idle_inputs();
        tick();
        chk("mid_pre_rvalid", {29'd0, rvalid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rvalid", {29'd0, rvalid},   32'd0);
        chk("mid_gnt",    {29'd0, gnt},      32'd0);
        chk("mid_en",     {31'd0, ram_en},   32'd0);
        chk("mid_addr",   {24'd0, ram_addr}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_idle_rv", {29'd0, rvalid}, 32'd0);
        run_vec(0);

        // All three request at once; each drops req after its grant
        req = 3'b111; we1 = 1'b0; we2 = 1'b1;
        addr0 = 8'h05; addr1 = 8'h10; addr2 = 8'h40; wdata2 = 8'h99;
        ngr = 0; last_cyc = 0; prev_wr = 1'b0; rv0 = 0; rv1 = 0; rv2 = 0;
        for (cyc = 1; cyc <= 40 && ngr < 3; cyc++) begin
            tick();
            chk("c3_excl", {31'd0, (gnt != 3'b000) && (rvalid != 3'b000)}, 32'd0);
            if (rvalid[0]) rv0++;
            if (rvalid[1]) rv1++;
            if (rvalid[2]) rv2++;
            if (gnt != 3'b000) begin
                chk($sformatf("c3_order%0d", ngr), {29'd0, gnt}, {29'd0, exp_ord3[ngr]});
                if (ngr > 0)
                    chk($sformatf("c3_gap%0d", ngr), cyc - last_cyc, prev_wr ? 32'd2 : 32'd3);
                prev_wr  = gnt[2];
                last_cyc = cyc;
                req      = req & ~gnt;
                ngr++;
            end
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rvalid[0]) rv0++;
            if (rvalid[1]) rv1++;
            if (rvalid[2]) rv2++;
        end
        chk("c3_grants", ngr, 32'd3);
        chk("c3_rv0", rv0, 32'd1);
        chk("c3_rv1", rv1, 32'd1);
        chk("c3_rv2", rv2, 32'd0);

        // Ports 0 and 2 keep requesting reads continuously
        req = 3'b101; addr0 = 8'h10; addr2 = 8'hFF;
        ngr = 0;
        for (cyc = 1; cyc <= 40 && ngr < 4; cyc++) begin
            tick();
            if (gnt != 3'b000) begin
                chk($sformatf("c2_order%0d", ngr), {29'd0, gnt}, {29'd0, exp_ord4[ngr]});
                ngr++;
            end
        end
        idle_inputs();
        chk("c2_grants", ngr, 32'd4);
        for (int k = 0; k < 4; k++)
            tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
